// File: rtl/add16_seq_pkg.sv
// Types and constants for add16_seq, built on the shared encoding header.
`include "add_seq_defs.v"

package add16_seq_pkg;

   localparam int SLICE_W = `ADD_SEQ_SLICE_W;

   typedef enum logic [1:0] {
      ST_IDLE = `ADD_SEQ_ST_IDLE,
      ST_RUN  = `ADD_SEQ_ST_RUN,
      ST_DONE = `ADD_SEQ_ST_DONE
   } state_e;

endpackage

// File: rtl/CLA4.sv
// 4-bit carry look-ahead adder: sum = a + b + cin, with every carry
// derived directly from generate/propagate terms rather than rippled.
module CLA4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[3:0];
   assign cout = c[4];

endmodule

// File: rtl/add_seq_defs.v
// FSM state encodings and slice width shared by the sequential adder files.
// Guarded so that several files may include it in one compilation.
`ifndef ADD_SEQ_DEFS_V
`define ADD_SEQ_DEFS_V

`define ADD_SEQ_SLICE_W  4
`define ADD_SEQ_ST_IDLE  2'd0
`define ADD_SEQ_ST_RUN   2'd1
`define ADD_SEQ_ST_DONE  2'd2

`endif

// File: rtl/add16_seq.sv
// Sequential adder/subtractor: one 4-bit slice per cycle, LSB first,
// through a single shared CLA4; subtraction is a + ~b + 1.
module add16_seq
   import add16_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       sub,
   input  logic [SLICE_W*NIBBLES-1:0] a,
   input  logic [SLICE_W*NIBBLES-1:0] b,
   output logic                       ready,
   output logic                       done,
   output logic [SLICE_W*NIBBLES-1:0] result,
   output logic                       cout,
   output logic                       ovf
);

   localparam int W     = SLICE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       result_q, result_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [SLICE_W-1:0] a_slice;
   logic [SLICE_W-1:0] b_slice;
   logic [SLICE_W-1:0] sum_slice;
   logic               slice_cout;

   assign a_slice = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
   assign b_slice = b_q[SLICE_W*int'(idx_q) +: SLICE_W];

   CLA4 u_cla4 (
      .a    (a_slice),
      .b    (b_slice),
      .cin  (carry_q),
      .sum  (sum_slice),
      .cout (slice_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b ^ {W{sub}};
               carry_d = sub;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            result_d[SLICE_W*int'(idx_q) +: SLICE_W] = sum_slice;
            carry_d = slice_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               // Top slice: its sum MSB is result[W-1], so overflow is known now.
               cout_d  = slice_cout;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_slice[SLICE_W-1] != a_q[W-1]);
               idx_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   // Operand registers only load on an accepted start, so they need no reset.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign ready  = (state_q == ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_add16_seq.sv
// Scoreboard bench for add16_seq: accepted operations push an arithmetic
// model result; a monitor pops and compares on every done pulse.
module tb_add16_seq;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         ready;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int op_id = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      int           t_acc;
      int           id;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   add16_seq #(.NIBBLES(NIB)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Plain integer arithmetic: unsigned for result/carry, signed range for overflow.
   function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t        e;
      int          ua, ub, sa, sb, ss;
      logic [31:0] us;
      ua = int'(x);
      ub = int'(y);
      sa = int'($signed(x));
      sb = int'($signed(y));
      if (!s) begin
         us   = 32'(ua + ub);
         e.co = (ua + ub) > 65535;
         ss   = sa + sb;
      end else begin
         us   = 32'(ua - ub);
         e.co = (ua >= ub);
         ss   = sa - sb;
      end
      e.res   = us[W-1:0];
      e.ov    = (ss > 32767) || (ss < -32768);
      e.t_acc = 0;
      e.id    = 0;
      return e;
   endfunction

   // Called at a negedge where ready=1 and start=1: acceptance is at the next edge.
   task automatic push_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      e       = model(s, x, y);
      e.t_acc = cyc + 1;
      e.id    = op_id;
      op_id++;
      sb_q.push_back(e);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) chk("ready_timeout", 32'(ready), 32'd1);
   endtask

   task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      int n;
      wait_ready();
      sub   = s;
      a     = x;
      b     = y;
      start = 1'b1;
      push_op(s, x, y);
      @(negedge clk);
      n = 0;
      // Busy period: operands scrambled and start toggled, all of which must be ignored.
      while (ready !== 1'b1 && n < 50) begin
         n++;
         a     = W'($urandom);
         b     = W'($urandom);
         sub   = 1'($urandom);
         start = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      chk("ready_low_cycles", 32'(n), 32'(NIB + 1));
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk($sformatf("op%0d_result", mon_e.id), 32'(result), 32'(mon_e.res));
            chk($sformatf("op%0d_cout", mon_e.id), 32'(cout), 32'(mon_e.co));
            chk($sformatf("op%0d_ovf", mon_e.id), 32'(ovf), 32'(mon_e.ov));
            chk($sformatf("op%0d_latency", mon_e.id), 32'(cyc + 1 - mon_e.t_acc), 32'(NIB + 1));
         end
      end
   end

   initial begin
      int prev;
      int nacc;
      logic s;
      logic [W-1:0] x, y;

      repeat (3) @(negedge clk);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);

      do_op(1'b0, 16'h1234, 16'h4321);
      do_op(1'b0, 16'hFFFF, 16'h0001);
      do_op(1'b0, 16'h7FFF, 16'h0001);
      do_op(1'b1, 16'h0005, 16'h0007);
      do_op(1'b1, 16'h8000, 16'h0001);
      do_op(1'b0, 16'h000F, 16'h0001);
      do_op(1'b0, 16'h0F00, 16'h0100);
      do_op(1'b1, 16'h1234, 16'h1234);
      do_op(1'b1, 16'h0000, 16'h8000);

      for (int i = 0; i < 40; i++) do_op(1'($urandom), W'($urandom), W'($urandom));

      // Start held high with operands changing every cycle.
      wait_ready();
      prev = -1;
      nacc = 0;
      for (int i = 0; i < 36; i++) begin
         s     = 1'($urandom);
         x     = W'($urandom);
         y     = W'($urandom);
         sub   = s;
         a     = x;
         b     = y;
         start = 1'b1;
         if (ready === 1'b1) begin
            push_op(s, x, y);
            if (prev >= 0) chk("accept_gap", 32'(cyc + 1 - prev), 32'(NIB + 2));
            prev = cyc + 1;
            nacc++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("accept_count", 32'(nacc), 32'd6);
      wait_ready();

      // Abort during the second RUN cycle.
      do_op(1'b1, 16'h8000, 16'h0001);
      wait_ready();
      sub   = 1'b0;
      a     = 16'h1113;
      b     = 16'h2222;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(ready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("abort_ready", 32'(ready), 32'd1);
      repeat (8) @(negedge clk);
      do_op(1'b0, 16'h0FFF, 16'h0001);
      do_op(1'b1, 16'h0001, 16'h0002);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
